// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply controller: request op_codes,
// FSM state values and the default multiply timeout.
package hilo_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MFHI  = 3'd3;
    localparam logic [2:0] OP_MFLO  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/hilo_mdu_ctrl_multu_fixup.sv
// Turns the signed 32x32 product into the unsigned one: each operand with its
// sign bit set contributes the other operand shifted into the upper word.
module multu_fixup (
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [63:0] product,
    output logic [63:0] product_u
);

    logic [63:0] adj1;
    logic [63:0] adj2;

    assign adj1      = op1[31] ? {op2, 32'b0} : 64'b0;
    assign adj2      = op2[31] ? {op1, 32'b0} : 64'b0;
    assign product_u = product + adj1 + adj2;

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply controller between decode and the combinational multiplier.
// Define HILO_MULTU_EN to support MULTU; otherwise MULTU flags err_illegal.
module hilo_mdu_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err_timeout,
    output logic        err_illegal,
    output logic        mult_begin,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic [63:0] product,
    input  logic        mult_end
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic             state;
    logic [CNT_W-1:0] wait_cnt;
    logic [63:0]      result;
    logic             accept;

`ifdef HILO_MULTU_EN
    logic        is_unsigned;
    logic [63:0] product_u;

    multu_fixup u_fixup (
        .op1       (mult_op1),
        .op2       (mult_op2),
        .product   (product),
        .product_u (product_u)
    );

    assign result = is_unsigned ? product_u : product;
`else
    assign result = product;
`endif

    // Handshake and multiplier strobe decode straight from state so an
    // asynchronous reset drops them without waiting for a clock.
    assign op_ready   = (state == ST_IDLE);
    assign busy       = (state == ST_RUN);
    assign mult_begin = (state == ST_RUN);
    assign accept     = op_valid & op_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            hi          <= '0;
            lo          <= '0;
            mult_op1    <= '0;
            mult_op2    <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
`ifdef HILO_MULTU_EN
            is_unsigned <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    case (op_code)
                        OP_NOP: ;
                        OP_MULT: begin
                            mult_op1 <= op_a;
                            mult_op2 <= op_b;
                            wait_cnt <= '0;
                            state    <= ST_RUN;
`ifdef HILO_MULTU_EN
                            is_unsigned <= 1'b0;
`endif
                        end
                        OP_MULTU: begin
`ifdef HILO_MULTU_EN
                            mult_op1    <= op_a;
                            mult_op2    <= op_b;
                            wait_cnt    <= '0;
                            is_unsigned <= 1'b1;
                            state       <= ST_RUN;
`else
                            err_illegal <= 1'b1;
`endif
                        end
                        OP_MFHI: begin
                            rd_data  <= hi;
                            rd_valid <= 1'b1;
                        end
                        OP_MFLO: begin
                            rd_data  <= lo;
                            rd_valid <= 1'b1;
                        end
                        OP_MTHI: hi <= op_a;
                        OP_MTLO: lo <= op_a;
                        default: err_illegal <= 1'b1;
                    endcase
                end
            end else begin
                // RUN: wait for the multiplier, abandoning the op on timeout.
                if (mult_end) begin
                    {hi, lo} <= result;
                    state    <= ST_IDLE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_timeout <= 1'b1;
                    state       <= ST_IDLE;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl with a behavioural multiplier and a
// read-data scoreboard; honours HILO_MULTU_EN like the design.
module tb_hilo_mdu_ctrl;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a, op_b;
    logic        op_ready, rd_valid, busy, err_timeout, err_illegal, mult_begin;
    logic [31:0] rd_data, hi, lo, mult_op1, mult_op2;
    logic [63:0] product;
    logic        mult_end;

    logic        stall, late_end, junk;
    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] rdq[$];
    logic [31:0] e_hi, e_lo;
    int          n;

    hilo_mdu_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .busy(busy), .hi(hi), .lo(lo),
        .err_timeout(err_timeout), .err_illegal(err_illegal),
        .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
        .product(product), .mult_end(mult_end)
    );

    always #5 clk = ~clk;

    // Combinational signed multiplier; junk/late_end inject a stray completion.
    assign product  = junk ? 64'hDEADBEEF_0BADF00D
                           : longint'($signed(mult_op1)) * longint'($signed(mult_op2));
    assign mult_end = (mult_begin & ~stall) | late_end;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        op_valid = 1'b1;
        op_code  = c;
        op_a     = a;
        op_b     = b;
        while (op_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) chk32("send_wait", 32'(w), 32'd0);
        step();
        op_valid = 1'b0;
        op_code  = OP_NOP;
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (rdq.size() == 0) chk32("rd_unexpected", 32'(rdq.size()), 32'd1);
            else chk32("rd_data", rd_data, rdq.pop_front());
        end
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = OP_NOP; op_a = '0; op_b = '0;
        stall = 1'b0; late_end = 1'b0; junk = 1'b0;
        #2;
        chk32("rst_hi", hi, 32'h0);
        chk32("rst_lo", lo, 32'h0);
        chk32("rst_op1", mult_op1, 32'h0);
        chk32("rst_op2", mult_op2, 32'h0);
        chk32("rst_rd_data", rd_data, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_begin", mult_begin, 1'b0);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk1("rst_err_to", err_timeout, 1'b0);
        chk1("rst_err_il", err_illegal, 1'b0);
        chk1("rst_ready", op_ready, 1'b1);
        step();
        rst = 1'b0;

        // MULT -3 x 7
        send(OP_MULT, 32'hFFFFFFFD, 32'd7);
        chk1("m1_busy", busy, 1'b1);
        chk1("m1_begin", mult_begin, 1'b1);
        chk1("m1_ready", op_ready, 1'b0);
        chk32("m1_op1", mult_op1, 32'hFFFFFFFD);
        chk32("m1_op2", mult_op2, 32'd7);
        step();
        chk1("m1_busy_done", busy, 1'b0);
        chk1("m1_begin_done", mult_begin, 1'b0);
        chk32("m1_hi", hi, 32'hFFFFFFFF);
        chk32("m1_lo", lo, 32'hFFFFFFEB);

        // MIN x MIN, MFHI presented while RUN stalls until completion
        send(OP_MULT, 32'h80000000, 32'h80000000);
        chk1("m2_ready", op_ready, 1'b0);
        rdq.push_back(32'h40000000);
        send(OP_MFHI, 32'h0, 32'h0);
        chk1("m2_rd_valid", rd_valid, 1'b1);
        chk32("m2_hi", hi, 32'h40000000);
        chk32("m2_lo", lo, 32'h00000000);
        step();
        chk1("rd_pulse_width", rd_valid, 1'b0);

        // MTHI / MTLO then back-to-back reads
        send(OP_MTHI, 32'h12345678, 32'h0);
        send(OP_MTLO, 32'hCAFEBABE, 32'h0);
        rdq.push_back(32'hCAFEBABE);
        send(OP_MFLO, 32'h0, 32'h0);
        rdq.push_back(32'h12345678);
        send(OP_MFHI, 32'h0, 32'h0);
        chk1("b2b_rd_valid", rd_valid, 1'b1);
        chk32("mt_hi", hi, 32'h12345678);
        chk32("mt_lo", lo, 32'hCAFEBABE);
        step();
        e_hi = 32'h12345678;
        e_lo = 32'hCAFEBABE;

        // MULTU
`ifdef HILO_MULTU_EN
        send(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        chk1("mu_busy", busy, 1'b1);
        step();
        chk32("mu_hi", hi, 32'h00000001);
        chk32("mu_lo", lo, 32'hFFFFFFFE);
        chk1("mu_err_il", err_illegal, 1'b0);
        send(OP_MULTU, 32'h80000000, 32'hFFFFFFFF);
        step();
        {e_hi, e_lo} = {32'h0, 32'h80000000} * {32'h0, 32'hFFFFFFFF};
        chk32("mu2_hi", hi, e_hi);
        chk32("mu2_lo", lo, e_lo);
`else
        send(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        chk1("mu_busy", busy, 1'b0);
        chk1("mu_err_il", err_illegal, 1'b1);
        step();
        chk32("mu_hi", hi, e_hi);
        chk32("mu_lo", lo, e_lo);
`endif

        // Undefined op_code 7
        send(3'd7, 32'h1, 32'h1);
        chk1("il_err", err_illegal, 1'b1);
        chk1("il_busy", busy, 1'b0);
        chk32("il_hi", hi, e_hi);

        // Timeout with MFHI held pending
        stall = 1'b1;
        send(OP_MULT, 32'd5, 32'd5);
        op_valid = 1'b1;
        op_code  = OP_MFHI;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk32("to_run_cycles", 32'(n), 32'd16);
        chk1("to_err", err_timeout, 1'b1);
        chk1("to_ready", op_ready, 1'b1);
        chk32("to_hi", hi, e_hi);
        chk32("to_lo", lo, e_lo);
        rdq.push_back(e_hi);
        step();
        op_valid = 1'b0;
        op_code  = OP_NOP;
        chk1("to_rd_valid", rd_valid, 1'b1);
        stall = 1'b0;

        // Stray mult_end while IDLE
        junk = 1'b1;
        late_end = 1'b1;
        step();
        step();
        late_end = 1'b0;
        junk = 1'b0;
        chk32("late_hi", hi, e_hi);
        chk32("late_lo", lo, e_lo);
        chk1("late_busy", busy, 1'b0);

        // Sticky flags survive further work
        send(OP_MULT, 32'hFFFFFFFF, 32'd3);
        step();
        chk32("st_hi", hi, 32'hFFFFFFFF);
        chk32("st_lo", lo, 32'hFFFFFFFD);
        chk1("st_err_to", err_timeout, 1'b1);
        chk1("st_err_il", err_illegal, 1'b1);

        // Asynchronous reset in the middle of RUN
        stall = 1'b1;
        send(OP_MULT, 32'd9, 32'd9);
        chk1("ar_busy_pre", busy, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk1("ar_begin", mult_begin, 1'b0);
        chk1("ar_busy", busy, 1'b0);
        chk32("ar_hi", hi, 32'h0);
        chk32("ar_lo", lo, 32'h0);
        chk1("ar_err_to", err_timeout, 1'b0);
        chk1("ar_err_il", err_illegal, 1'b0);
        chk1("ar_ready", op_ready, 1'b1);
        step();
        rst = 1'b0;
        stall = 1'b0;
        send(OP_MULT, 32'd2, 32'd3);
        step();
        chk32("pr_hi", hi, 32'h0);
        chk32("pr_lo", lo, 32'd6);

        step();
        chk32("rd_pending", 32'(rdq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
